// File: rtl/gpu_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gpu_fifo_pkg
// Description : Shared constants, types and helpers for the FIFO stream
//               reader. These cover the output buffer depth, the transfer
//               counter width and the read-issue room check.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_fifo_pkg;

    // Depth of the output skid buffer behind the non-showahead FIFO.
    localparam int BUF_DEPTH   = 2;
    // Width of the buffer occupancy counter (holds 0..BUF_DEPTH).
    localparam int BUF_COUNT_W = 2;
    // Width of the accepted-transfer counter.
    localparam int OUT_COUNT_W = 32;

    localparam logic [BUF_COUNT_W-1:0] BUF_EMPTY = '0;
    localparam logic [BUF_COUNT_W-1:0] BUF_FULL  = BUF_COUNT_W'(BUF_DEPTH);

    typedef logic [BUF_COUNT_W-1:0] buf_count_t;

    // True when a word read now is guaranteed a slot on arrival. Slots are
    // committed by buffered words and by the read already in flight; a pop
    // this cycle frees one slot.
    function automatic logic room_for_read(
        input buf_count_t count,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] committed;
        committed = {1'b0, count} + {2'b00, inflight};
        return committed < (3'(BUF_DEPTH) + {2'b00, pop});
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_out_buffer
// Description : Two-entry in-order output buffer. Entry 0 is always the
//               head, so the head register never moves while no pop occurs.
//               A clear overrides any push or pop that happens in the same
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_out_buffer
    import gpu_fifo_pkg::*;
#(
    parameter int lpm_width = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [lpm_width-1:0]   push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [lpm_width-1:0]   head,
    output logic [BUF_COUNT_W-1:0] count
);

    logic [lpm_width-1:0]   entry0_q, entry0_d;
    logic [lpm_width-1:0]   entry1_q, entry1_d;
    logic [BUF_COUNT_W-1:0] count_q,  count_d;
    logic                   do_pop;

    // Next-state for the two entries and the occupancy, keeping FIFO order.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != BUF_EMPTY);

        if (clear) begin
            count_d = BUF_EMPTY;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    // A push into a full buffer cannot happen when reads are
                    // issued against free room, so it is simply ignored.
                    if (count_q == BUF_EMPTY) begin
                        entry0_d = push_data;
                        count_d  = count_q + BUF_COUNT_W'(1);
                    end else if (count_q != BUF_FULL) begin
                        entry1_d = push_data;
                        count_d  = count_q + BUF_COUNT_W'(1);
                    end
                end
                2'b01: begin
                    entry0_d = entry1_q;
                    count_d  = count_q - BUF_COUNT_W'(1);
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word goes behind
                    // whatever remains after the head leaves.
                    if (count_q == BUF_COUNT_W'(1)) begin
                        entry0_d = push_data;
                    end else begin
                        entry0_d = entry1_q;
                        entry1_d = push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= BUF_EMPTY;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head  = entry0_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Drains a non-showahead FIFO into a valid/ready stream. Reads
//               are issued only when the word returning next cycle is sure
//               of a buffer slot. This gives one word per cycle under full
//               throughput and at most two words held under back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import gpu_fifo_pkg::*;
#(
    parameter int lpm_width  = 32,
    parameter int lpm_widthu = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [lpm_width-1:0]   fifo_q,
    input  logic                   fifo_empty,
    input  logic [lpm_widthu-1:0]  fifo_usedw,
    output logic                   fifo_rdreq,
    output logic                   fifo_sclr,
    input  logic                   flush,
    output logic [lpm_width-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_COUNT_W-1:0] out_count
);

    logic                   inflight_q, inflight_d;
    logic [OUT_COUNT_W-1:0] out_count_q, out_count_d;
    logic [BUF_COUNT_W-1:0] buf_count;
    logic                   pop;
    logic                   rdreq;
    logic                   buf_push;

    // The fill level is informational only; fold it so it is visibly consumed.
    logic unused_usedw;
    assign unused_usedw = ^fifo_usedw;

    // Read issue, in-flight tracking and transfer counting.
    always_comb begin
        pop         = (buf_count != BUF_EMPTY) && out_ready;
        // Gating with reset_n keeps the request low while reset is held.
        rdreq       = reset_n && !fifo_empty && !flush
                      && room_for_read(buf_count, inflight_q, pop);
        inflight_d  = rdreq;
        out_count_d = out_count_q;
        if (flush) begin
            out_count_d = '0;
        end else if (pop) begin
            out_count_d = out_count_q + OUT_COUNT_W'(1);
        end
    end

    // In-flight flag and transfer counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q  <= 1'b0;
            out_count_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            out_count_q <= out_count_d;
        end
    end

    // A word returning during a flush belongs to the discarded stream.
    assign buf_push = inflight_q && !flush;

    fifo_out_buffer #(
        .lpm_width (lpm_width)
    ) u_buf (
        .clk       (clock),
        .rst_n     (reset_n),
        .push      (buf_push),
        .push_data (fifo_q),
        .pop       (pop),
        .clear     (flush),
        .head      (out_data),
        .count     (buf_count)
    );

    assign out_valid  = (buf_count != BUF_EMPTY);
    assign fifo_rdreq = rdreq;
    assign fifo_sclr  = reset_n && flush;
    assign out_count  = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Self-checking bench for fifo_stream_reader. It contains a
//               queue-based FIFO, a word-level scoreboard and a set of
//               directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [31:0] fifo_q     = '0;
    logic        fifo_empty = 1'b1;
    logic [3:0]  fifo_usedw = '0;
    logic        fifo_rdreq;
    logic        fifo_sclr;
    logic        flush      = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready  = 1'b0;
    logic [31:0] out_count;

    logic        wr_en      = 1'b0;
    logic [31:0] wr_data    = '0;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_stream_reader #(
        .lpm_width  (32),
        .lpm_widthu (4)
    ) dut (
        .clock      (clk),
        .reset_n    (reset_n),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_usedw (fifo_usedw),
        .fifo_rdreq (fifo_rdreq),
        .fifo_sclr  (fifo_sclr),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-showahead FIFO: read data is registered; the FIFO is not reset by reset_n.
    logic [31:0] fifo_mem[$];
    always @(posedge clk) begin
        if (fifo_sclr) begin
            fifo_mem.delete();
        end else begin
            if (fifo_rdreq && fifo_mem.size() != 0) fifo_q <= fifo_mem.pop_front();
            if (wr_en) fifo_mem.push_back(wr_data);
        end
        fifo_empty <= (fifo_mem.size() == 0);
        fifo_usedw <= 4'(fifo_mem.size());
    end

    // Scoreboard: every word read from the FIFO becomes visible two cycles
    // after its read request and leaves in read order.
    typedef struct {
        logic [31:0] data;
        int          avail;
    } ent_t;
    ent_t        sb[$];
    int          cyc        = 0;
    logic [31:0] m_count    = '0;
    int          total_pops = 0;
    logic        m_exp_valid;
    logic        m_pop;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            check("rst_valid", out_valid, 0);
            check("rst_data", out_data, 0);
            check("rst_count", out_count, 0);
            check("rst_rdreq", fifo_rdreq, 0);
            check("rst_sclr", fifo_sclr, 0);
            sb.delete();
            m_count = '0;
        end else begin
            m_exp_valid = (sb.size() != 0) && (sb[0].avail <= cyc);
            check("valid", out_valid, m_exp_valid);
            if (m_exp_valid) check("data", out_data, sb[0].data);
            check("out_count", out_count, m_count);
            check("sclr", fifo_sclr, flush);
            check("rdreq_while_empty", fifo_rdreq & fifo_empty, 0);
            m_pop = out_valid && out_ready;
            if (m_pop) total_pops++;
            if (flush) begin
                sb.delete();
                m_count = '0;
            end else if (m_pop && sb.size() != 0) begin
                void'(sb.pop_front());
                m_count = m_count + 32'd1;
            end
            if (fifo_rdreq && fifo_mem.size() != 0)
                sb.push_back('{data: fifo_mem[0], avail: cyc + 2});
            check("outstanding_le_2", (sb.size() <= 2), 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, k, nr, nv, nw, idle, drained, base;

        // Reset state, with other inputs active.
        flush     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_valid", out_valid, 0);
        check("t1_data", out_data, 0);
        check("t1_count", out_count, 0);
        check("t1_rdreq", fifo_rdreq, 0);
        check("t1_sclr", fifo_sclr, 0);
        tick();
        flush = 1'b0;

        // Streaming: preload 0x10..0x17 while held in reset.
        for (int i = 0; i < 8; i++) begin
            tick();
            wr_en   = 1'b1;
            wr_data = 32'h10 + 32'(i);
        end
        tick();
        wr_en   = 1'b0;
        reset_n = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rdreq) begin
                found = 1;
                break;
            end
        end
        check("t2_rdreq_seen", found, 1);
        @(negedge clk);
        check("t2_valid_n1", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_stream_valid", out_valid, 1);
            check("t2_stream_data", out_data, 32'h10 + 32'(i));
        end
        @(negedge clk);
        check("t2_valid_end", out_valid, 0);
        check("t2_count", out_count, 8);

        // Back-pressure: 4 words queued, consumer stalled.
        tick();
        out_ready = 1'b0;
        nr = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            wr_en   = (i < 4);
            wr_data = 32'h10 + 32'(i);
            @(negedge clk);
            if (fifo_rdreq) nr++;
        end
        check("t3_rdreq_pulses", nr, 2);
        check("t3_valid_held", out_valid, 1);
        check("t3_head_data", out_data, 32'h10);
        tick();
        out_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check("t3_order", out_data, 32'h10 + 32'(k));
                k++;
            end
        end
        check("t3_words", k, 4);
        check("t3_count", out_count, 12);

        // Empty boundary: a single word.
        nr = 0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            wr_en   = (i == 0);
            wr_data = 32'hAA;
            @(negedge clk);
            if (fifo_rdreq) nr++;
            if (out_valid) begin
                nv++;
                check("t4_data", out_data, 32'hAA);
            end
        end
        check("t4_rdreq_once", nr, 1);
        check("t4_valid_once", nv, 1);
        check("t4_valid_low", out_valid, 0);
        check("t4_count", out_count, 13);

        // Flush in the cycle after a read with two words committed.
        tick();
        out_ready = 1'b0;
        nr = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            wr_en   = (i < 3);
            wr_data = 32'h30 + 32'(i);
            @(negedge clk);
            if (fifo_rdreq) nr++;
            if (nr == 2) break;
        end
        check("t5_two_reads", nr, 2);
        tick();
        wr_en = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("t5_sclr", fifo_sclr, 1);
        check("t5_rdreq_low", fifo_rdreq, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t5_valid_low", out_valid, 0);
        check("t5_count_clr", out_count, 0);
        nr = 0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fifo_rdreq) nr++;
            if (out_valid) nv++;
        end
        check("t5_no_reads", nr, 0);
        check("t5_no_valid", nv, 0);

        // Asynchronous reset mid-stream.
        tick();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            wr_en   = 1'b1;
            wr_data = 32'h50 + 32'(i);
        end
        tick();
        wr_en   = 1'b0;
        reset_n = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check("t6_pre_data", out_data, 32'h50 + 32'(k));
                k++;
                if (k == 2) break;
            end
        end
        check("t6_pre_words", k, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_rdreq", fifo_rdreq, 0);
        check("t6_async_count", out_count, 0);
        tick();
        tick();
        reset_n = 1'b1;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check("t6_resume_data", out_data, 32'h53 + 32'(k));
                k++;
            end
        end
        check("t6_resume_words", k, 3);

        // Random traffic with random back-pressure.
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        base = total_pops;
        nw   = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            out_ready = ($urandom_range(0, 9) < 7);
            wr_en     = ($urandom_range(0, 9) < 4);
            wr_data   = 32'hC000_0000 + 32'(nw);
            if (wr_en) nw++;
        end
        tick();
        wr_en     = 1'b0;
        out_ready = 1'b1;
        idle    = 0;
        drained = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fifo_mem.size() == 0 && !out_valid && !fifo_rdreq) begin
                idle++;
                if (idle >= 3) begin
                    drained = 1;
                    break;
                end
            end else begin
                idle = 0;
            end
        end
        check("t7_drained", drained, 1);
        check("t7_transfers", total_pops - base, nw);
        check("t7_count", out_count, nw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter lpm_width, default 32: data word width in bits, 1 or greater.
REQ-002 Parameter lpm_widthu, default 4: width of the FIFO fill-level input.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 fifo_q  input  lpm_width  FIFO read data (non-showahead); valid in the cycle after fifo_rdreq is high.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_usedw  input  lpm_widthu  FIFO fill level; status only, not used for control.
REQ-008 fifo_rdreq  output  1  FIFO read request.
REQ-009 fifo_sclr  output  1  FIFO synchronous clear.
REQ-010 flush  input  1  one-cycle request to drop all buffered and in-flight data.
REQ-011 out_data  output  lpm_width  stream data, registered.
REQ-012 out_valid  output  1  stream valid, registered.
REQ-013 out_ready  input  1  stream ready from the consumer.
REQ-014 out_count  output  32  count of accepted stream transfers.

Function
REQ-015 The block shall hold a 2-entry output buffer (count 0..2) plus a 1-bit in-flight flag marking a read issued in the previous cycle.
REQ-016 A transfer occurs when out_valid and out_ready are both high in the same cycle (pop).
REQ-017 fifo_rdreq = !fifo_empty && !flush && (count + inflight - pop) < 2, evaluated combinationally in the current cycle.
REQ-018 inflight shall load the value of fifo_rdreq at every edge.
REQ-019 When inflight is high, fifo_q shall be written into the buffer tail at the clock edge ending that cycle.
REQ-020 A simultaneous pop and write shall leave count unchanged and keep FIFO order.
REQ-021 out_valid = (count != 0); out_data = buffer head; the head shall stay stable while out_valid is high and out_ready is low.
REQ-022 Latency: fifo_rdreq in cycle N shall give out_valid with that word in cycle N+2 when the buffer was empty.
REQ-023 Throughput: with out_ready held high and the FIFO non-empty, the block shall deliver one word per cycle indefinitely.
REQ-024 Back-pressure: with out_ready low, at most 2 words shall be buffered, and fifo_rdreq shall be low once count + inflight = 2.
REQ-025 fifo_sclr shall equal flush, combinationally.
REQ-026 On a flush cycle, the following shall occur at that edge:
- count goes to 0 and inflight goes to 0;
- any word returning from the read issued in the cycle before the flush is discarded;
- out_count clears to 0;
- a pop in the flush cycle still counts as a transfer to the consumer but is not added to out_count.
REQ-027 fifo_rdreq shall never be asserted while fifo_empty is high (no underflow reliance on the FIFO).
REQ-028 out_count shall increment by 1 per pop and wrap from 2^32-1 to 0.

Reset
REQ-029 While reset_n is low, the block shall asynchronously force:
- count=0, inflight=0;
- out_valid=0, out_data=0, out_count=0;
- fifo_rdreq=0, fifo_sclr=0, regardless of the other inputs.
REQ-030 On reset_n deassertion, the first fifo_rdreq may occur in the first cycle after the release edge; buffer contents from before reset shall never be emitted.

Structure
REQ-031 The buffer depth constant (2) and the out_count width (32) shall live in the shared package gpu_fifo_pkg.
REQ-032 The 2-entry buffer shall be a sub-module fifo_out_buffer with ports push, push_data, pop, clear, head, count.
REQ-033 The top level shall contain only the read-issue logic, the in-flight flag and out_count; it shall use no latches and no negative-edge logic.

Verification
REQ-034 Streaming: FIFO preloaded with 0x10..0x17, out_ready=1 -> out_valid rises 2 cycles after the first rdreq, words 0x10..0x17 appear on 8 consecutive cycles, out_count=8.
REQ-035 Back-pressure: 4 words queued, out_ready=0 -> exactly 2 rdreq pulses, out_valid held with data 0x10; on out_ready=1 the words appear in order with no loss or duplication.
REQ-036 Empty boundary: a single word 0xAA written to an empty FIFO -> exactly one rdreq, out_data=0xAA, then out_valid=0; rdreq is never high while fifo_empty=1.
REQ-037 Flush: flush asserted in the cycle after an rdreq with 2 words buffered -> fifo_sclr=1 that cycle, the in-flight word is discarded, out_valid=0 next cycle, out_count=0.
REQ-038 Reset: reset_n pulled low mid-stream (asynchronously, between edges) -> out_valid=0 and rdreq=0 immediately; after release the stream resumes from the FIFO head.
REQ-039 Random: random out_ready and random FIFO writes for 10000 cycles -> output sequence equals the input sequence, and out_count equals the number of transfers.
